// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - multi-slot fruit generator with LFSR placement, eat detection and score
//
// Holds NUM_FRUIT grid-aligned fruit positions. A free-running 16-bit Galois
// LFSR proposes one candidate cell per frame. FILL places every slot in order.
// RUN watches for the snake head landing on a fruit. RESPAWN re-places the
// slot that was just eaten.
//
// Optional build macro:
//   FOOD_AVOID_BORDER_EN  when defined, the outer ring of cells is never used
//
// Ports:
//   frame_clk    clock, one tick per video frame
//   Reset        asynchronous, active-high reset
//   enable       1 = eat detection active, 0 = game paused
//   head_x       snake head pixel X (grid-aligned)
//   head_y       snake head pixel Y (grid-aligned)
//   fruit_x      packed fruit X, slot i at [10i+9:10i]
//   fruit_y      packed fruit Y, slot i at [10i+9:10i]
//   fruit_valid  per-slot live flag
//   eaten        one-cycle pulse when a fruit is eaten
//   eaten_idx    slot that was eaten; meaningful only while eaten=1
//   score        saturating count of fruits eaten
module food_spawner #(
    parameter int          NUM_FRUIT = 2,
    parameter int          GRID      = 10,
    parameter int          X_CELLS   = 60,
    parameter int          Y_CELLS   = 43,
    parameter int          X_OFFSET  = 40,
    parameter int          Y_OFFSET  = 40,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          SCORE_W   = 8
) (
    input  logic                                               frame_clk,
    input  logic                                               Reset,
    input  logic                                               enable,
    input  logic [9:0]                                         head_x,
    input  logic [9:0]                                         head_y,
    output logic [10*NUM_FRUIT-1:0]                            fruit_x,
    output logic [10*NUM_FRUIT-1:0]                            fruit_y,
    output logic [NUM_FRUIT-1:0]                               fruit_valid,
    output logic                                               eaten,
    output logic [((NUM_FRUIT > 1) ? $clog2(NUM_FRUIT) : 1)-1:0] eaten_idx,
    output logic [SCORE_W-1:0]                                 score
);

    localparam int IDX_W = (NUM_FRUIT > 1) ? $clog2(NUM_FRUIT) : 1;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_RUN     = 2'd1,
        S_RESPAWN = 2'd2
    } state_t;

    state_t                   state, state_n;
    logic [15:0]              lfsr, lfsr_n;
    logic [IDX_W-1:0]         ptr, ptr_n;
    logic [10*NUM_FRUIT-1:0]  fx_n, fy_n;
    logic [NUM_FRUIT-1:0]     valid_n;
    logic                     eaten_n;
    logic [IDX_W-1:0]         idx_n;
    logic [SCORE_W-1:0]       score_n;

    logic [5:0]               cx, cy;
    logic [9:0]               px, py;
    logic                     cand_ok;
    logic                     hit;
    logic [IDX_W-1:0]         hit_idx;

    // Candidate cell straight from the current LFSR value; out-of-range cells
    // may wrap in px/py but are rejected by the range test below.
    assign cx = lfsr[5:0];
    assign cy = lfsr[13:8];
    assign px = 10'(X_OFFSET) + 10'(cx) * 10'(GRID);
    assign py = 10'(Y_OFFSET) + 10'(cy) * 10'(GRID);

    // Right-shift Galois step; the feedback bit is XORed into the tap positions.
    assign lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        cand_ok = (int'(cx) < X_CELLS) && (int'(cy) < Y_CELLS);
`ifdef FOOD_AVOID_BORDER_EN
        if ((cx == 6'd0) || (int'(cx) == X_CELLS - 1) ||
            (cy == 6'd0) || (int'(cy) == Y_CELLS - 1))
            cand_ok = 1'b0;
`endif
        if ((px == head_x) && (py == head_y))
            cand_ok = 1'b0;
        // The slot being placed is never valid here, so comparing against all
        // valid slots is the same as comparing against the other ones.
        for (int i = 0; i < NUM_FRUIT; i++) begin
            if (fruit_valid[i] && (fruit_x[10*i +: 10] == px) && (fruit_y[10*i +: 10] == py))
                cand_ok = 1'b0;
        end
    end

    // Descending scan so the lowest matching slot is the one left in hit_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_FRUIT - 1; i >= 0; i--) begin
            if (fruit_valid[i] && (fruit_x[10*i +: 10] == head_x) && (fruit_y[10*i +: 10] == head_y)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        fx_n    = fruit_x;
        fy_n    = fruit_y;
        valid_n = fruit_valid;
        eaten_n = 1'b0;
        idx_n   = eaten_idx;
        score_n = score;

        case (state)
            S_FILL, S_RESPAWN: begin
                if (cand_ok) begin
                    for (int i = 0; i < NUM_FRUIT; i++) begin
                        if (IDX_W'(i) == ptr) begin
                            fx_n[10*i +: 10] = px;
                            fy_n[10*i +: 10] = py;
                            valid_n[i]       = 1'b1;
                        end
                    end
                    if (state == S_RESPAWN) begin
                        state_n = S_RUN;
                    end else if (ptr == IDX_W'(NUM_FRUIT - 1)) begin
                        state_n = S_RUN;
                        ptr_n   = '0;
                    end else begin
                        ptr_n = ptr + IDX_W'(1);
                    end
                end
            end

            S_RUN: begin
                if (enable && hit) begin
                    eaten_n = 1'b1;
                    idx_n   = hit_idx;
                    for (int i = 0; i < NUM_FRUIT; i++) begin
                        if (IDX_W'(i) == hit_idx)
                            valid_n[i] = 1'b0;
                    end
                    if (score != {SCORE_W{1'b1}})
                        score_n = score + SCORE_W'(1);
                    ptr_n   = hit_idx;
                    state_n = S_RESPAWN;
                end
            end

            default: begin
                state_n = S_FILL;
                ptr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_FILL;
            lfsr        <= SEED;
            ptr         <= '0;
            fruit_x     <= '0;
            fruit_y     <= '0;
            fruit_valid <= '0;
            eaten       <= 1'b0;
            eaten_idx   <= '0;
            score       <= '0;
        end else begin
            state       <= state_n;
            lfsr        <= lfsr_n;
            ptr         <= ptr_n;
            fruit_x     <= fx_n;
            fruit_y     <= fy_n;
            fruit_valid <= valid_n;
            eaten       <= eaten_n;
            eaten_idx   <= idx_n;
            score       <= score_n;
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// tb/tb_food_spawner.sv - scoreboard testbench for food_spawner
module tb_food_spawner;

    localparam int N  = 2;
    localparam int SW = 2;

    logic          frame_clk = 1'b0;
    logic          Reset     = 1'b1;
    logic          enable    = 1'b0;
    logic [9:0]    head_x    = '0;
    logic [9:0]    head_y    = '0;
    logic [19:0]   fruit_x;
    logic [19:0]   fruit_y;
    logic [1:0]    fruit_valid;
    logic          eaten;
    logic [0:0]    eaten_idx;
    logic [SW-1:0] score;

    food_spawner #(.SCORE_W(SW)) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .enable      (enable),
        .head_x      (head_x),
        .head_y      (head_y),
        .fruit_x     (fruit_x),
        .fruit_y     (fruit_y),
        .fruit_valid (fruit_valid),
        .eaten       (eaten),
        .eaten_idx   (eaten_idx),
        .score       (score)
    );

    always #5 frame_clk = ~frame_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model, stepped once per rising edge
    logic [15:0]   m_lfsr;
    int            m_state;     // 0 fill, 1 run, 2 respawn
    int            m_ptr;
    logic [9:0]    m_fx [N];
    logic [9:0]    m_fy [N];
    logic [1:0]    m_valid;
    logic          m_eaten;
    logic          m_idx;
    logic [SW-1:0] m_score;

    typedef struct {
        logic [19:0]   fx;
        logic [19:0]   fy;
        logic [1:0]    valid;
        logic          eaten;
        logic          idx;
        logic [SW-1:0] score;
    } exp_t;

    exp_t sb_q[$];

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_state = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) begin
            m_fx[i] = '0;
            m_fy[i] = '0;
        end
        m_valid = '0;
        m_eaten = 1'b0;
        m_idx   = 1'b0;
        m_score = '0;
    endtask

    task automatic model_step();
        int         cx, cy;
        logic [9:0] px, py;
        bit         ok;
        bit         done;
        cx = int'(m_lfsr[5:0]);
        cy = int'(m_lfsr[13:8]);
        px = 10'(40 + cx * 10);
        py = 10'(40 + cy * 10);
        ok = (cx < 60) && (cy < 43) && !((px == head_x) && (py == head_y));
`ifdef FOOD_AVOID_BORDER_EN
        if (cx == 0 || cx == 59 || cy == 0 || cy == 42) ok = 0;
`endif
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_fx[i] == px && m_fy[i] == py) ok = 0;
        m_eaten = 1'b0;
        if (m_state != 1) begin
            if (ok) begin
                m_fx[m_ptr]    = px;
                m_fy[m_ptr]    = py;
                m_valid[m_ptr] = 1'b1;
                if (m_state == 2) m_state = 1;
                else if (m_ptr == N - 1) begin m_state = 1; m_ptr = 0; end
                else m_ptr++;
            end
        end else if (enable) begin
            done = 0;
            for (int i = 0; i < N; i++) begin
                if (!done && m_valid[i] && m_fx[i] == head_x && m_fy[i] == head_y) begin
                    done       = 1;
                    m_eaten    = 1'b1;
                    m_idx      = 1'(i);
                    m_valid[i] = 1'b0;
                    if (m_score != {SW{1'b1}}) m_score++;
                    m_ptr   = i;
                    m_state = 2;
                end
            end
        end
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    // Called just after a falling edge: drive inputs, predict, then compare
    // at the next falling edge.
    task automatic step(input logic en, input logic [9:0] hx, input logic [9:0] hy);
        exp_t e;
        enable = en;
        head_x = hx;
        head_y = hy;
        model_step();
        e.fx    = {m_fx[1], m_fx[0]};
        e.fy    = {m_fy[1], m_fy[0]};
        e.valid = m_valid;
        e.eaten = m_eaten;
        e.idx   = m_idx;
        e.score = m_score;
        sb_q.push_back(e);
        @(negedge frame_clk);
        check("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_valid", 64'(fruit_valid), 64'(e.valid));
            check("sb_eaten", 64'(eaten), 64'(e.eaten));
            check("sb_score", 64'(score), 64'(e.score));
            check("sb_fx", 64'(fruit_x), 64'(e.fx));
            check("sb_fy", 64'(fruit_y), 64'(e.fy));
            if (e.eaten) check("sb_idx", 64'(eaten_idx), 64'(e.idx));
        end
    endtask

    task automatic wait_full(input string tag, input logic en, input logic [9:0] hx, input logic [9:0] hy);
        int k;
        k = 0;
        while (fruit_valid != 2'b11 && k < 256) begin
            step(en, hx, hy);
            k++;
        end
        check(tag, 64'(fruit_valid), 64'h3);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(fruit_valid), 64'h0);
        check({tag, "_score"}, 64'(score), 64'h0);
        check({tag, "_eaten"}, 64'(eaten), 64'h0);
        check({tag, "_fx"}, 64'(fruit_x), 64'h0);
        check({tag, "_fy"}, 64'(fruit_y), 64'h0);
    endtask

    logic [41:0] snap [256];
    int          n_fill;
    int          exp_score [5] = '{1, 2, 3, 3, 3};

    initial begin
        logic [9:0] ox, oy, hx, hy;
        int         x, y, pulses;

        model_reset();
        repeat (2) @(negedge frame_clk);
        check_zero("rst");
        Reset = 1'b0;

        // Initial fill, recorded for the deterministic replay check
        n_fill = 0;
        while (fruit_valid != 2'b11 && n_fill < 256) begin
            step(1'b0, 10'd0, 10'd0);
            snap[n_fill] = {fruit_x, fruit_y, fruit_valid};
            n_fill++;
        end
        check("fill_done", 64'(fruit_valid), 64'h3);

        for (int i = 0; i < N; i++) begin
            x = int'(fruit_x[10*i +: 10]);
            y = int'(fruit_y[10*i +: 10]);
            check("x_grid", 64'((x - 40) % 10), 64'd0);
            check("y_grid", 64'((y - 40) % 10), 64'd0);
            check("x_range", 64'(x >= 40 && x <= 630), 64'd1);
            check("y_range", 64'(y >= 40 && y <= 460), 64'd1);
        end
        check("distinct", 64'({fruit_x[9:0], fruit_y[9:0]} != {fruit_x[19:10], fruit_y[19:10]}), 64'd1);

        // Eat slot 0
        ox = fruit_x[9:0];
        oy = fruit_y[9:0];
        step(1'b1, ox, oy);
        check("eat0_pulse", 64'(eaten), 64'd1);
        check("eat0_idx", 64'(eaten_idx), 64'd0);
        check("eat0_valid0", 64'(fruit_valid[0]), 64'd0);
        check("eat0_score", 64'(score), 64'(exp_score[0]));
        wait_full("refill0", 1'b1, ox, oy);
        check("respawn_cell", 64'({fruit_x[9:0], fruit_y[9:0]} != {ox, oy}), 64'd1);

        // Paused with head on slot 1
        hx = fruit_x[19:10];
        hy = fruit_y[19:10];
        pulses = 0;
        repeat (20) begin
            step(1'b0, hx, hy);
            pulses += int'(eaten);
        end
        check("pause_eaten", 64'(pulses), 64'd0);
        check("pause_score", 64'(score), 64'(exp_score[0]));
        step(1'b1, hx, hy);
        check("eat1_pulse", 64'(eaten), 64'd1);
        check("eat1_idx", 64'(eaten_idx), 64'd1);
        check("eat1_score", 64'(score), 64'(exp_score[1]));
        wait_full("refill1", 1'b1, hx, hy);

        // Saturation: three more eats
        for (int k = 2; k < 5; k++) begin
            ox = fruit_x[9:0];
            oy = fruit_y[9:0];
            step(1'b1, ox, oy);
            check("sat_pulse", 64'(eaten), 64'd1);
            check("sat_score", 64'(score), 64'(exp_score[k]));
            wait_full("sat_refill", 1'b1, ox, oy);
        end

        // Reset in the middle of RESPAWN, then replay the fill from SEED
        ox = fruit_x[9:0];
        oy = fruit_y[9:0];
        step(1'b1, ox, oy);
        check("pre_rst_pulse", 64'(eaten), 64'd1);
        #2 Reset = 1'b1;
        #1 check_zero("midrst");
        model_reset();
        sb_q.delete();
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
        for (int k = 0; k < n_fill; k++) begin
            step(1'b0, 10'd0, 10'd0);
            check("replay", 64'({fruit_x, fruit_y, fruit_valid}), 64'(snap[k]));
        end
        check("replay_full", 64'(fruit_valid), 64'h3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
